// File: rtl/mem_a_skew_pkg.sv
// Shared types and default sizes for the skewed matrix feeder.
// Holds the stream FSM state enum and default element width / dimension.
package mem_a_skew_pkg;

  localparam int DEF_BITS_AB = 32;
  localparam int DEF_DIM     = 8;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

endpackage

// File: rtl/mem_a_lane.sv
// One lane of the skew feeder: one storage row plus a registered output.
// Ports: row/column write inputs, stream count t, aout/avalid registered.
module mem_a_lane
  import mem_a_skew_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM,
  parameter int LANE    = 0,
  parameter int IW      = $clog2(DIM),
  parameter int TW      = $clog2(2 * DIM)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   row_we,
  input  logic [DIM*BITS_AB-1:0] row_data,
  input  logic                   col_we,
  input  logic [IW-1:0]          col_sel,
  input  logic [BITS_AB-1:0]     col_data,
  input  logic                   active,
  input  logic [TW-1:0]          t,
  output logic [BITS_AB-1:0]     aout,
  output logic                   avalid
);

  localparam logic [TW-1:0] LO = TW'(LANE);
  localparam logic [TW-1:0] HI = TW'(LANE + DIM);

  logic [BITS_AB-1:0] row [DIM];
  logic               in_rng;
  logic [IW-1:0]      col;

  // This lane emits column t-LANE while that column exists.
  assign in_rng = active && (t >= LO) && (t < HI);
  assign col    = IW'(t - LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int c = 0; c < DIM; c++) begin
        row[c] <= '0;
      end
    end else if (row_we) begin
      for (int c = 0; c < DIM; c++) begin
        row[c] <= row_data[c*BITS_AB +: BITS_AB];
      end
    end else if (col_we) begin
      row[col_sel] <= col_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      aout   <= '0;
      avalid <= 1'b0;
    end else if (in_rng) begin
      aout   <= row[col];
      avalid <= 1'b1;
    end else begin
      aout   <= '0;
      avalid <= 1'b0;
    end
  end

endmodule

// File: rtl/mem_a_skew.sv
// DIM x DIM matrix store that streams its rows out diagonally skewed.
// Ports: clk/rst_n, wr_en/wr_idx/transpose/Ain write, go, Aout/Avalid/busy/done.
module mem_a_skew
  import mem_a_skew_pkg::*;
#(
  parameter int BITS_AB = DEF_BITS_AB,
  parameter int DIM     = DEF_DIM
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DIM)-1:0]   wr_idx,
  input  logic                     transpose,
  input  logic [DIM*BITS_AB-1:0]   Ain,
  input  logic                     go,
  output logic [DIM*BITS_AB-1:0]   Aout,
  output logic [DIM-1:0]           Avalid,
  output logic                     busy,
  output logic                     done
);

  localparam int IW = $clog2(DIM);
  localparam int TW = $clog2(2 * DIM);
  // One extra all-idle count after the last beat produces the done slot.
  localparam logic [TW-1:0] TLAST = TW'(2 * DIM - 1);
  localparam logic [IW:0]   DIM_W = (IW + 1)'(DIM);

  state_t        state_q, state_n;
  logic [TW-1:0] t_q, t_n;
  logic          done_q, done_n;
  logic          wr_ok;
  logic          active;

  assign active = (state_q == STREAM);
  assign busy   = active;
  assign done   = done_q;
  assign wr_ok  = wr_en && !active && ({1'b0, wr_idx} < DIM_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      t_q     <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      t_q     <= t_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state_q;
    t_n     = t_q;
    done_n  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          state_n = STREAM;
          t_n     = '0;
        end
      end
      STREAM: begin
        if (t_q == TLAST) begin
          state_n = IDLE;
          t_n     = '0;
          done_n  = 1'b1;
        end else begin
          t_n = t_q + 1'b1;
        end
      end
      default: begin
        state_n = IDLE;
        t_n     = '0;
      end
    endcase
  end

  for (genvar r = 0; r < DIM; r++) begin : g_lane
    logic row_we;
    assign row_we = wr_ok && !transpose && (wr_idx == IW'(r));

    mem_a_lane #(
      .BITS_AB (BITS_AB),
      .DIM     (DIM),
      .LANE    (r),
      .IW      (IW),
      .TW      (TW)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .row_we   (row_we),
      .row_data (Ain),
      .col_we   (wr_ok && transpose),
      .col_sel  (wr_idx),
      .col_data (Ain[r*BITS_AB +: BITS_AB]),
      .active   (active),
      .t        (t_q),
      .aout     (Aout[r*BITS_AB +: BITS_AB]),
      .avalid   (Avalid[r])
    );
  end

endmodule

// File: tb/tb_mem_a_skew.sv
// Directed bench for mem_a_skew at DIM=4, BITS_AB=8.
// Table of per-cycle expected stream beats plus hand-written sequences.
module tb_mem_a_skew;

  localparam int BITS = 8;
  localparam int DIM  = 4;

  logic            clk;
  logic            rst_n;
  logic            wr_en;
  logic [1:0]      wr_idx;
  logic            transpose;
  logic [31:0]     Ain;
  logic            go;
  logic [31:0]     Aout;
  logic [3:0]      Avalid;
  logic            busy;
  logic            done;

  int n_run;
  int n_fail;

  typedef struct {
    logic [3:0]  valid;
    logic [31:0] aout;
    logic        busy;
    logic        done;
  } beat_t;

  beat_t tbl [9];

  mem_a_skew #(.BITS_AB(BITS), .DIM(DIM)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en     (wr_en),
    .wr_idx    (wr_idx),
    .transpose (transpose),
    .Ain       (Ain),
    .go        (go),
    .Aout      (Aout),
    .Avalid    (Avalid),
    .busy      (busy),
    .done      (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic wr(input logic [1:0] idx, input logic tr,
                    input logic [31:0] d);
    wr_en = 1'b1; wr_idx = idx; transpose = tr; Ain = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // mode 0: normal, 1: write row2=-1 with go, 2: zero data,
  // 3: write 0x7F during stream. chain: extra go mid-stream and on done.
  task automatic stream(input int mode, input bit chain, input string nm);
    logic [31:0] e;
    go = 1'b1;
    if (mode == 1) begin
      wr_en = 1'b1; wr_idx = 2'd2; transpose = 1'b0; Ain = 32'hFFFF_FFFF;
    end
    @(posedge clk); #1;
    go = 1'b0; wr_en = 1'b0;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) begin
        @(posedge clk); #1;
      end
      go = 1'b0; wr_en = 1'b0;
      e = tbl[k].aout;
      if (mode == 2) e = '0;
      if (mode == 1 && tbl[k].valid[2]) e[23:16] = 8'hFF;
      check($sformatf("%s c%0d", nm, k),
            {26'd0, busy, done, Avalid, Aout},
            {26'd0, tbl[k].busy, tbl[k].done, tbl[k].valid, e});
      if (mode == 3 && k == 2) begin
        wr_en = 1'b1; wr_idx = 2'd1; transpose = 1'b0; Ain = 32'h7F7F_7F7F;
      end
      if (chain && k == 3) go = 1'b1;
      if (chain && k == 8) go = 1'b1;
    end
  endtask

  task automatic write_rows();
    for (int r = 0; r < 4; r++) begin
      wr(2'(r), 1'b0, {8'(10*r+3), 8'(10*r+2), 8'(10*r+1), 8'(10*r)});
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    int seen;
    n_run = 0; n_fail = 0;
    tbl[0] = '{4'b0000, 32'h0000_0000, 1'b1, 1'b0};
    tbl[1] = '{4'b0001, 32'h0000_0000, 1'b1, 1'b0};
    tbl[2] = '{4'b0011, 32'h0000_0A01, 1'b1, 1'b0};
    tbl[3] = '{4'b0111, 32'h0014_0B02, 1'b1, 1'b0};
    tbl[4] = '{4'b1111, 32'h1E15_0C03, 1'b1, 1'b0};
    tbl[5] = '{4'b1110, 32'h1F16_0D00, 1'b1, 1'b0};
    tbl[6] = '{4'b1100, 32'h2017_0000, 1'b1, 1'b0};
    tbl[7] = '{4'b1000, 32'h2100_0000, 1'b1, 1'b0};
    tbl[8] = '{4'b0000, 32'h0000_0000, 1'b0, 1'b1};

    rst_n = 1'b0; wr_en = 1'b0; wr_idx = '0; transpose = 1'b0;
    Ain = '0; go = 1'b0;
    #12;
    check("reset outs", {26'd0, busy, done, Avalid, Aout}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    write_rows();
    stream(0, 1'b0, "rows");

    do_reset();
    for (int c = 0; c < 4; c++) begin
      wr(2'(c), 1'b1, {8'(30+c), 8'(20+c), 8'(10+c), 8'(c)});
    end
    stream(0, 1'b0, "cols");

    stream(3, 1'b0, "wr_in_stream");
    stream(0, 1'b0, "replay");

    stream(1, 1'b0, "wr_go_same");

    go = 1'b1;
    @(posedge clk); #1;
    go = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    check("mid reset outs", {26'd0, busy, done, Avalid, Aout}, 64'd0);
    #3;
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("no done after reset", 64'(seen), 64'd0);
    stream(2, 1'b0, "zero");

    write_rows();
    stream(0, 1'b1, "chain1");
    stream(0, 1'b0, "chain2");
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk); #1;
      if (busy || Avalid != 4'b0) seen++;
    end
    check("idle after chain", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
